hsv_profile_sched: RTL

- Time-multiplexes one runtime-programmable HSV threshold datapath across up to four colour profiles (red, blue, orange, spare), switching profile on frame boundaries.
- Holds a shadow/active threshold register bank written over a valid/ready config port. Commits shadow to active only at frame start, so a frame is never thresholded with mixed bounds.
- Sits between the RGB→HSV converter and the blob/centroid logic. Emits an 8-bit mask (255/0) tagged with the profile id that produced it.

---
 rtl/hsv_sched_pkg.sv | 45 ++++
 rtl/hsv_profile_sched_if.sv | 34 +++
 rtl/hsv_range_cmp.sv | 23 ++
 rtl/hsv_profile_sched.sv | 135 +++++++++++++
 4 files changed

// File: rtl/hsv_sched_pkg.sv
// rtl/hsv_sched_pkg.sv - shared types, field codes and reset bounds for hsv_profile_sched
package hsv_sched_pkg;

  localparam int NUM_PROF = 4;
  localparam int PROF_W   = 2;

  localparam logic [2:0] FLD_HLO = 3'd0;
  localparam logic [2:0] FLD_HHI = 3'd1;
  localparam logic [2:0] FLD_SLO = 3'd2;
  localparam logic [2:0] FLD_SHI = 3'd3;
  localparam logic [2:0] FLD_VLO = 3'd4;
  localparam logic [2:0] FLD_VHI = 3'd5;
  localparam logic [2:0] FLD_EN  = 3'd6;

  typedef struct packed {
    logic [7:0] hlo;
    logic [7:0] hhi;
    logic [7:0] slo;
    logic [7:0] shi;
    logic [7:0] vlo;
    logic [7:0] vhi;
  } bounds_t;

  typedef enum logic {ST_IDLE, ST_PENDING} commit_st_t;

  localparam bounds_t P0_DEF = '{hlo: 8'd246, hhi: 8'd6,   slo: 8'd80, shi: 8'd230, vlo: 8'd220, vhi: 8'd255};
  localparam bounds_t P1_DEF = '{hlo: 8'd140, hhi: 8'd170, slo: 8'd80, shi: 8'd255, vlo: 8'd100, vhi: 8'd255};
  localparam bounds_t P2_DEF = '{hlo: 8'd15,  hhi: 8'd35,  slo: 8'd70, shi: 8'd230, vlo: 8'd220, vhi: 8'd255};
  localparam bounds_t P3_DEF = '{hlo: 8'd0,   hhi: 8'd255, slo: 8'd0,  shi: 8'd255, vlo: 8'd0,   vhi: 8'd255};

  localparam bounds_t [NUM_PROF-1:0] BANK_DEF = {P3_DEF, P2_DEF, P1_DEF, P0_DEF};
  localparam logic [NUM_PROF-1:0]    EN_DEF   = 4'b0111;

  // {found, id}: nearest enabled profile after cur, wrapping back to cur itself last.
  function automatic logic [PROF_W:0] next_enabled(input logic [PROF_W-1:0] cur,
                                                   input logic [NUM_PROF-1:0] en);
    logic [PROF_W-1:0] id;
    next_enabled = {1'b0, cur};
    for (int k = NUM_PROF; k >= 1; k--) begin
      id = cur + PROF_W'(k);
      if (en[id]) next_enabled = {1'b1, id};
    end
  endfunction

endpackage

// File: rtl/hsv_profile_sched_if.sv
// rtl/hsv_profile_sched_if.sv - frame control, config port and pixel stream of hsv_profile_sched
interface hsv_profile_sched_if;
  logic       frame_start;
  logic       sched_fixed;
  logic [1:0] fixed_sel;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_profile;
  logic [2:0] cfg_field;
  logic [7:0] cfg_data;
  logic       cfg_commit;
  logic       commit_done;
  logic       pix_valid;
  logic [7:0] H;
  logic [7:0] S;
  logic [7:0] V;
  logic [7:0] color;
  logic       out_valid;
  logic [1:0] out_profile;
  logic [1:0] cur_profile;
  logic       none_enabled;

  modport master (
    output frame_start, sched_fixed, fixed_sel, cfg_valid, cfg_profile, cfg_field,
           cfg_data, cfg_commit, pix_valid, H, S, V,
    input  cfg_ready, commit_done, color, out_valid, out_profile, cur_profile, none_enabled
  );

  modport slave (
    input  frame_start, sched_fixed, fixed_sel, cfg_valid, cfg_profile, cfg_field,
           cfg_data, cfg_commit, pix_valid, H, S, V,
    output cfg_ready, commit_done, color, out_valid, out_profile, cur_profile, none_enabled
  );
endinterface

// File: rtl/hsv_range_cmp.sv
// rtl/hsv_range_cmp.sv - combinational per-channel HSV bounds check, hue range may wrap
module hsv_range_cmp
  import hsv_sched_pkg::*;
(
  input  bounds_t    i_b,
  input  logic [7:0] i_h,
  input  logic [7:0] i_s,
  input  logic [7:0] i_v,
  output logic       o_h_ok,
  output logic       o_s_ok,
  output logic       o_v_ok
);

  logic w_h_wrap;

  // Hue is circular: lo>hi selects the band crossing 255->0; S/V have no such meaning.
  assign w_h_wrap = i_b.hlo > i_b.hhi;
  assign o_h_ok   = w_h_wrap ? ((i_h >= i_b.hlo) || (i_h <= i_b.hhi))
                             : ((i_h >= i_b.hlo) && (i_h <= i_b.hhi));
  assign o_s_ok   = (i_s >= i_b.slo) && (i_s <= i_b.shi);
  assign o_v_ok   = (i_v >= i_b.vlo) && (i_v <= i_b.vhi);

endmodule

// File: rtl/hsv_profile_sched.sv
// rtl/hsv_profile_sched.sv - frame-switched HSV threshold profiles with shadow/active bank and 2-stage mask pipe
module hsv_profile_sched
  import hsv_sched_pkg::*;
(
  input logic               clock,
  input logic               reset,
  hsv_profile_sched_if.slave bus
);

  bounds_t [NUM_PROF-1:0] r_sh;
  bounds_t [NUM_PROF-1:0] r_act;
  logic    [NUM_PROF-1:0] r_sh_en;
  logic    [NUM_PROF-1:0] r_act_en;
  commit_st_t             r_st;
  logic                   r_cfg_ready;
  logic                   r_commit_done;
  logic    [PROF_W-1:0]   r_cur;

  logic    [2:0]          r_s1_flags;
  logic                   r_s1_valid;
  logic    [PROF_W-1:0]   r_s1_prof;
  logic    [7:0]          r_color;
  logic                   r_out_valid;
  logic    [PROF_W-1:0]   r_out_prof;

  logic                   w_wr;
  logic                   w_apply;
  logic    [NUM_PROF-1:0] w_en_next;
  logic    [PROF_W:0]     w_nxt;
  logic                   w_none;
  logic                   w_gate;
  logic                   w_h_ok;
  logic                   w_s_ok;
  logic                   w_v_ok;

  assign w_wr      = bus.cfg_valid & r_cfg_ready;
  assign w_apply   = (r_st == ST_PENDING) & bus.frame_start;
  assign w_en_next = w_apply ? r_sh_en : r_act_en;
  assign w_nxt     = next_enabled(r_cur, w_en_next);
  assign w_none    = ~|r_act_en;
  assign w_gate    = ~(w_none & ~bus.sched_fixed);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_st          <= ST_IDLE;
      r_cfg_ready   <= 1'b1;
      r_commit_done <= 1'b0;
      r_sh          <= BANK_DEF;
      r_sh_en       <= EN_DEF;
      r_act         <= BANK_DEF;
      r_act_en      <= EN_DEF;
    end else begin
      r_commit_done <= 1'b0;
      case (r_st)
        ST_IDLE: begin
          if (w_wr) begin
            case (bus.cfg_field)
              FLD_HLO: r_sh[bus.cfg_profile].hlo <= bus.cfg_data;
              FLD_HHI: r_sh[bus.cfg_profile].hhi <= bus.cfg_data;
              FLD_SLO: r_sh[bus.cfg_profile].slo <= bus.cfg_data;
              FLD_SHI: r_sh[bus.cfg_profile].shi <= bus.cfg_data;
              FLD_VLO: r_sh[bus.cfg_profile].vlo <= bus.cfg_data;
              FLD_VHI: r_sh[bus.cfg_profile].vhi <= bus.cfg_data;
              FLD_EN:  r_sh_en[bus.cfg_profile]  <= bus.cfg_data[0];
              default: ;
            endcase
          end
          if (bus.cfg_commit) begin
            r_st        <= ST_PENDING;
            r_cfg_ready <= 1'b0;
          end
        end
        ST_PENDING: begin
          // Whole bank swaps at once so no frame ever sees a half-updated profile.
          if (bus.frame_start) begin
            r_act         <= r_sh;
            r_act_en      <= r_sh_en;
            r_commit_done <= 1'b1;
            r_cfg_ready   <= 1'b1;
            r_st          <= ST_IDLE;
          end
        end
        default: r_st <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cur <= '0;
    end else if (bus.frame_start) begin
      if (bus.sched_fixed)  r_cur <= bus.fixed_sel;
      else if (w_nxt[PROF_W]) r_cur <= w_nxt[PROF_W-1:0];
    end
  end

  hsv_range_cmp u_cmp (
    .i_b    (r_act[r_cur]),
    .i_h    (bus.H),
    .i_s    (bus.S),
    .i_v    (bus.V),
    .o_h_ok (w_h_ok),
    .o_s_ok (w_s_ok),
    .o_v_ok (w_v_ok)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s1_flags  <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_prof   <= '0;
      r_color     <= '0;
      r_out_valid <= 1'b0;
      r_out_prof  <= '0;
    end else begin
      r_s1_flags  <= {w_h_ok, w_s_ok, w_v_ok} & {3{w_gate}};
      r_s1_valid  <= bus.pix_valid;
      r_s1_prof   <= r_cur;
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_color    <= (&r_s1_flags) ? 8'd255 : 8'd0;
        r_out_prof <= r_s1_prof;
      end
    end
  end

  assign bus.cfg_ready    = r_cfg_ready;
  assign bus.commit_done  = r_commit_done;
  assign bus.color        = r_color;
  assign bus.out_valid    = r_out_valid;
  assign bus.out_profile  = r_out_prof;
  assign bus.cur_profile  = r_cur;
  assign bus.none_enabled = w_none;

endmodule
